// File: rtl/uart_rx_pkg.sv
// Shared types for the UART RX batch FIFO: send-FSM states and the stored entry layout.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_NUM,
      S_WAIT_NUM,
      S_POP,
      S_WAIT_ACK
   } send_state_e;

   localparam int RX_DATA_W = 8;

   // Frame-error flag sits above the payload, so an entry is DATA_W+1 bits wide.
   typedef struct packed {
      logic                 ferr;
      logic [RX_DATA_W-1:0] data;
   } rx_entry_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port RAM with synchronous write and synchronous read.
// The array is not reset; only the read register is.
module uart_fifo_ram #(
   parameter int W     = 9,
   parameter int DEPTH = 512,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/uart_rx_batch_fifo.sv
// Receive buffer between the UART RX deserializer and the CPU: stores words with frame-error
// flags, announces batches by count IRQ (threshold or idle timeout) and hands them out under ack.
module uart_rx_batch_fifo
   import uart_rx_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 512,
   parameter int AW     = $clog2(DEPTH),
   parameter int TMO_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_ferr,
   output logic              wr_ready,
   input  logic [AW:0]       threshold,
   input  logic [TMO_W-1:0]  timeout,
   output logic              num_irq,
   output logic [AW:0]       num_out,
   input  logic              num_ack,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_ferr,
   input  logic              rd_ack,
   output logic [AW:0]       level,
   output logic              overflow,
   input  logic              ovf_clr,
   output logic              busy,
   output send_state_e       state_dbg
);

   // Handshakes: a write is taken on any cycle wr_valid is high while wr_ready is high;
   // num_ack is honoured only in WAIT_NUM and rd_ack only in WAIT_ACK, all others are ignored.
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   send_state_e         state, state_nxt;
   logic [AW-1:0]       wptr, rptr;
   logic [AW:0]         count, batch, sent, thr_eff;
   logic [TMO_W-1:0]    idle_cnt;
   logic [DATA_W:0]     rdata;
   logic                push, pop, go;

   assign wr_ready  = (count != FULL);
   assign push      = wr_valid && wr_ready && !flush;
   assign pop       = (state == S_POP) && !flush;
   assign level     = count;
   assign busy      = (state != S_IDLE);
   assign num_irq   = (state == S_NUM);
   assign state_dbg = state;
   assign rd_data   = rdata[DATA_W-1:0];
   assign rd_ferr   = rdata[DATA_W];

   always_comb begin
      thr_eff = threshold;
      if (threshold == '0)       thr_eff = (AW+1)'(1);
      else if (threshold > FULL) thr_eff = FULL;
   end

   assign go = (count >= thr_eff) ||
               ((timeout != '0) && (count != '0) && (idle_cnt >= timeout));

   uart_fifo_ram #(.W(DATA_W+1), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (push),
      .waddr (wptr),
      .wdata ({wr_ferr, wr_data}),
      .re    (pop),
      .raddr (rptr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (go) state_nxt = S_NUM;
         S_NUM:      state_nxt = S_WAIT_NUM;
         S_WAIT_NUM: if (num_ack) state_nxt = S_POP;
         S_POP:      state_nxt = S_WAIT_ACK;
         S_WAIT_ACK: if (rd_ack) state_nxt = (sent == batch) ? S_IDLE : S_POP;
         default:    state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         idle_cnt <= '0;
         batch    <= '0;
         sent     <= '0;
         num_out  <= '0;
         rd_valid <= 1'b0;
      end else if (flush) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         idle_cnt <= '0;
         batch    <= '0;
         sent     <= '0;
         num_out  <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);

         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase

         // Idle timer only runs while words wait in IDLE; it saturates instead of wrapping.
         if ((state == S_IDLE) && (count != '0) && !push) begin
            if (idle_cnt != '1) idle_cnt <= idle_cnt + TMO_W'(1);
         end else begin
            idle_cnt <= '0;
         end

         // Batch size is latched on entry to NUM so num_out is already valid during the IRQ pulse.
         if ((state == S_IDLE) && go) begin
            batch   <= count;
            num_out <= count;
         end

         if ((state == S_WAIT_NUM) && num_ack) sent <= '0;
         else if (pop)                         sent <= sent + (AW+1)'(1);

         if (pop) begin
            rd_valid <= 1'b1;
         end else if ((state == S_WAIT_ACK) && rd_ack) begin
            rd_valid <= 1'b0;
            if (sent == batch) num_out <= '0;
         end
      end
   end

   // A dropped write sets overflow even if ovf_clr is asserted in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   overflow <= 1'b0;
      else if (wr_valid && !wr_ready) overflow <= 1'b1;
      else if (ovf_clr)             overflow <= 1'b0;
   end

endmodule

// File: tb/tb_uart_rx_batch_fifo.sv
// Directed self-checking bench for uart_rx_batch_fifo with DEPTH=8.
module tb_uart_rx_batch_fifo;
   import uart_rx_pkg::*;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int AW     = 3;
   localparam int TMO_W  = 16;
   localparam int W      = $bits(rx_entry_t);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              wr_valid = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_ferr = 1'b0;
   logic              wr_ready;
   logic [AW:0]       threshold = '0;
   logic [TMO_W-1:0]  timeout = '0;
   logic              num_irq;
   logic [AW:0]       num_out;
   logic              num_ack = 1'b0;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_ferr;
   logic              rd_ack = 1'b0;
   logic [AW:0]       level;
   logic              overflow;
   logic              ovf_clr = 1'b0;
   logic              busy;
   send_state_e       state_dbg;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   uart_rx_batch_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ferr(wr_ferr), .wr_ready(wr_ready),
      .threshold(threshold), .timeout(timeout),
      .num_irq(num_irq), .num_out(num_out), .num_ack(num_ack),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ferr(rd_ferr), .rd_ack(rd_ack),
      .level(level), .overflow(overflow), .ovf_clr(ovf_clr), .busy(busy),
      .state_dbg(state_dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // driver tasks
   task automatic write_word(input logic [DATA_W-1:0] d, input logic f, input logic acc);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_ferr  = f;
      tick();
      wr_valid = 1'b0;
      wr_ferr  = 1'b0;
      if (acc) exp_q.push_back({f, d});
   endtask

   task automatic wait_irq(input int exp_n, input logic [AW:0] exp_num);
      int n = 0;
      while (!num_irq && n < 400) begin
         tick();
         n++;
      end
      check("irq_seen", num_irq, 1);
      check("irq_latency", n, exp_n);
      check("num_out", num_out, exp_num);
      tick();
      check("irq_pulse_end", num_irq, 0);
      check("num_out_held", num_out, exp_num);
   endtask

   task automatic do_num_ack();
      num_ack = 1'b1;
      tick();
      num_ack = 1'b0;
      check("pop_cycle_rd_low", rd_valid, 0);
      tick();
      check("rd_valid_after_ack", rd_valid, 1);
   endtask

   task automatic read_word(input int exp_wait);
      int n = 0;
      logic [W-1:0] exp;
      while (!rd_valid && n < 20) begin
         tick();
         n++;
      end
      check("rd_valid_seen", rd_valid, 1);
      check("rd_gap", n, exp_wait);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check("rd_word", {rd_ferr, rd_data}, exp);
      tick();
      check("rd_hold", {rd_valid, rd_ferr, rd_data}, {1'b1, exp});
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      check("rd_drop", rd_valid, 0);
   endtask

   task automatic drain(input int k);
      for (int i = 0; i < k; i++) read_word(1);
   endtask

   // Fills to 8 with one dropped write and parks the FSM in WAIT_ACK on the first word.
   task automatic prep_full_batch(input logic [DATA_W-1:0] base);
      threshold = 4'd8;
      for (int i = 0; i < 8; i++) write_word(base + DATA_W'(i), 1'b0, 1'b1);
      write_word(base + DATA_W'(8), 1'b0, 1'b0);
      tick();
      check("prep_wait_num", state_dbg, S_WAIT_NUM);
      do_num_ack();
   endtask

   initial begin
      // reset
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("rst_wr_ready", wr_ready, 1);
      check("rst_level", level, 0);
      check("rst_outputs", {num_irq, num_out, rd_valid, rd_ferr, rd_data, overflow, busy}, 0);
      check("rst_state", state_dbg, S_IDLE);

      // threshold 5, frame error on the third word
      threshold = 4'd5;
      write_word(8'h11, 1'b0, 1'b1);
      write_word(8'h12, 1'b0, 1'b1);
      write_word(8'h13, 1'b1, 1'b1);
      write_word(8'h14, 1'b0, 1'b1);
      write_word(8'h15, 1'b0, 1'b1);
      check("t1_level", level, 5);
      wait_irq(1, 5);
      do_num_ack();
      read_word(0);
      drain(4);
      check("t1_done", {busy, num_out, level}, 0);

      // idle timeout: last write cycle t, irq at t+timeout+2, i.e. 101 ticks after it
      threshold = 4'd8;
      timeout   = 16'd100;
      write_word(8'h21, 1'b0, 1'b1);
      write_word(8'h22, 1'b0, 1'b1);
      write_word(8'h23, 1'b0, 1'b1);
      wait_irq(101, 3);
      do_num_ack();
      read_word(0);
      drain(2);
      timeout = '0;

      // threshold 9 clamps to 8; writes 9 and 10 are dropped
      threshold = 4'd9;
      for (int i = 0; i < 8; i++) write_word(8'h30 + 8'(i), 1'b0, 1'b1);
      check("t3_full_ready", wr_ready, 0);
      check("t3_full_level", level, 8);
      write_word(8'h38, 1'b0, 1'b0);
      write_word(8'h39, 1'b0, 1'b0);
      check("t3_overflow", overflow, 1);
      check("t3_level", level, 8);
      check("t3_busy", busy, 1);
      check("t3_num_out", num_out, 8);
      do_num_ack();
      read_word(0);
      drain(7);
      repeat (3) tick();
      check("t3_no_extra", {rd_valid, busy, level}, 0);
      check("t3_ovf_sticky", overflow, 1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("t3_ovf_clr", overflow, 0);

      // write during WAIT_ACK is excluded from the running batch
      threshold = 4'd5;
      for (int i = 0; i < 5; i++) write_word(8'h41 + 8'(i), 1'b0, 1'b1);
      wait_irq(1, 5);
      do_num_ack();
      write_word(8'h46, 1'b0, 1'b1);
      check("t4_level_mid", level, 5);
      read_word(0);
      drain(4);
      check("t4_level_after", level, 1);
      check("t4_idle", {busy, num_out}, 0);
      for (int i = 0; i < 4; i++) write_word(8'h47 + 8'(i), 1'b0, 1'b1);
      wait_irq(1, 5);
      do_num_ack();
      read_word(0);
      drain(4);

      // flush mid-batch keeps overflow
      prep_full_batch(8'h51);
      check("t5_ovf_before", overflow, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t5_flush_rd", rd_valid, 0);
      check("t5_flush_busy", busy, 0);
      check("t5_flush_level", level, 0);
      check("t5_flush_ovf", overflow, 1);
      check("t5_flush_num", num_out, 0);
      exp_q.delete();

      // threshold 0 acts as 1; also shows pointers restart together after flush
      threshold = 4'd0;
      write_word(8'hA5, 1'b1, 1'b1);
      wait_irq(1, 1);
      do_num_ack();
      read_word(0);
      check("t5_after_level", level, 0);

      // reset mid-batch clears overflow as well
      prep_full_batch(8'h61);
      rst_n = 1'b0;
      #1;
      check("t6_rst_rd", rd_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_level", level, 0);
      check("t6_rst_ovf", overflow, 0);
      check("t6_rst_ready", wr_ready, 1);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      tick();

      // final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_batch_fifo.md
# uart_rx_batch_fifo

Parametrised receive buffer between the UART RX deserializer and the CPU-facing register/IRQ block. Stores received words with their frame-error flags, and announces a batch to the CPU by count IRQ once a programmable threshold is reached or an idle timeout expires. It then hands the batch out word by word under an ack handshake. It adds true-full detection, overflow reporting, idle-timeout flush and synchronous flush.

## Interface
- DATA_W, 8, payload width per entry
- DEPTH, 512, entries; power of 2, ≥4
- AW, $clog2(DEPTH), pointer width (derived)
- TMO_W, 16, idle-timeout counter width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of pointers, count, FSM
- wr_valid  in  1  one-cycle pulse: word available from RX
- wr_data  in  DATA_W  received word
- wr_ferr  in  1  frame error for wr_data
- wr_ready  out  1  high when count<DEPTH
- threshold  in  AW+1  batch trigger level; 0 treated as 1, >DEPTH treated as DEPTH
- timeout  in  TMO_W  idle cycles before partial batch; 0 disables
- num_irq  out  1  one-cycle pulse: batch size valid
- num_out  out  AW+1  batch size, held until batch done
- num_ack  in  1  CPU consumed num_out
- rd_valid  out  1  rd_data/rd_ferr valid, held until rd_ack
- rd_data  out  DATA_W  popped word
- rd_ferr  out  1  frame error of popped word
- rd_ack  in  1  CPU consumed current word
- level  out  AW+1  current occupancy
- overflow  out  1  sticky: write dropped while full
- ovf_clr  in  1  clears overflow
- busy  out  1  FSM not in IDLE

## Operation
- Write: wr_valid && count<DEPTH → mem[wptr]={wr_ferr,wr_data}, wptr+1 mod DEPTH. wr_valid while full → word dropped, overflow←1.
- Count AW+1 bits, full at count==DEPTH (all entries usable). Push and pop in same cycle → count unchanged.
- Idle timer: in IDLE with count≠0, increments each cycle without a write, saturates; cleared by any accepted write, or when count==0, or outside IDLE.
- Send FSM states: IDLE, NUM, WAIT_NUM, POP, WAIT_ACK.
  - IDLE→NUM when count≥thr_eff, or timeout≠0 && count≠0 && idle_timer≥timeout.
  - NUM (1 cycle): batch←count, num_out←count, num_irq=1 → WAIT_NUM.
  - WAIT_NUM: num_ack → POP, sent←0.
  - POP (1 cycle): rd_data/rd_ferr←mem[rptr], rptr+1, sent+1, rd_valid←1 → WAIT_ACK.
  - WAIT_ACK: rd_ack → rd_valid←0; sent==batch → IDLE (num_out←0), else POP.
- Writes during a batch are accepted but excluded from it; they trigger the next batch from IDLE.
- overflow set has priority over ovf_clr in the same cycle.
- flush: wptr, rptr, count, timer, FSM→IDLE, all handshake outputs→0 next cycle; overflow unaffected; a write in the flush cycle is discarded.
- num_ack/rd_ack outside their wait states are ignored.

## Timing
- Reset: all outputs 0 except wr_ready=1; mem not reset.
- Write to level update: 1 cycle.
- Threshold reached (count registered) → num_irq next cycle (state NUM), then 1 cycle pulse.
- num_ack → rd_valid high 2 cycles later (POP, then registered output).
- rd_ack → next rd_valid 2 cycles later; rd_valid low ≥1 cycle between words.
- Timeout: last write at cycle t → num_irq at t+timeout+2.

## Structure
- Package uart_rx_pkg: send-state enum, entry typedef {ferr, data} of width DATA_W+1.
- Sub-module uart_fifo_ram: simple dual-port RAM, DEPTH×(DATA_W+1), synchronous write, synchronous read; control FSM and pointers stay in top.

## Test plan
- thr=5, timeout=0, write 0x11..0x15 → num_irq with num_out=5; after num_ack, rd_data 0x11..0x15 in order, each held until rd_ack.
- thr=8, timeout=100, write 3 words then idle → num_irq at 102 cycles after last write, num_out=3.
- DEPTH=8, thr=9 (clamped to 8), write 10 words without ack → wr_ready=0 after 8th, overflow=1, level=8, batch returns first 8 only.
- Write during WAIT_ACK of a 5-word batch → batch ends after 5 words, level=1 after final ack, new batch when threshold met.
- wr_ferr=1 on 3rd word → rd_ferr=1 only with 3rd popped word.
- flush asserted mid-batch in WAIT_ACK → next cycle rd_valid=0, busy=0, level=0, overflow preserved; reset mid-batch gives same plus overflow=0.
